// File: rtl/alu_req_driver_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_req_driver_if
// Description : Bundles the three buses of alu_req_driver:
//                 request port  (req_valid/req_ready/req_val1/req_val2/req_mode)
//                 response port (rsp_valid/rsp_ready/rsp_result/rsp_timeout)
//                 ALU side      (val1/val2/mode/valid_i out, valid_o/result in)
//               master : the driver (alu_req_driver)
//               slave  : the environment (requester, response sink and ALU)
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_req_driver_if #(
    parameter int WIDTH  = 8,
    parameter int MODE_W = 3,
    parameter int RES_W  = 16
);
    // Request port
    logic              req_valid;
    logic              req_ready;
    logic [WIDTH-1:0]  req_val1;
    logic [WIDTH-1:0]  req_val2;
    logic [MODE_W-1:0] req_mode;
    // Response port
    logic              rsp_valid;
    logic              rsp_ready;
    logic [RES_W-1:0]  rsp_result;
    logic              rsp_timeout;
    // ALU side
    logic [WIDTH-1:0]  val1;
    logic [WIDTH-1:0]  val2;
    logic [MODE_W-1:0] mode;
    logic              valid_i;
    logic              valid_o;
    logic [RES_W-1:0]  result;

    modport master (
        input  req_valid, req_val1, req_val2, req_mode, rsp_ready, valid_o, result,
        output req_ready, rsp_valid, rsp_result, rsp_timeout, val1, val2, mode, valid_i
    );

    modport slave (
        output req_valid, req_val1, req_val2, req_mode, rsp_ready, valid_o, result,
        input  req_ready, rsp_valid, rsp_result, rsp_timeout, val1, val2, mode, valid_i
    );
endinterface
`default_nettype wire

// File: rtl/alu_req_driver.sv
`default_nettype none
// ============================================================================
// Module      : alu_req_driver
// Description : On-chip initiator for the ALU operand/result interface.
//               Requests are queued in a DEPTH-entry FIFO and issued one at a
//               time; each issue waits for valid_o (bounded by TIMEOUT cycles)
//               and the result, or a timeout marker, is presented on a
//               ready/valid response port.
// Ports       : clk       - clock, rising edge
//               rst       - asynchronous active-high reset
//               bus       - alu_req_driver_if.master (request, response, ALU)
//               busy      - FSM not idle or FIFO not empty
//               err_stray - sticky, valid_o seen with no op outstanding
// Revision    : 1.0 - initial release
// ============================================================================
module alu_req_driver #(
    parameter int WIDTH   = 8,
    parameter int MODE_W  = 3,
    parameter int RES_W   = 16,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  wire logic        clk,
    input  wire logic        rst,
    alu_req_driver_if.master bus,
    output logic             busy,
    output logic             err_stray
);
    localparam int         c_AW      = $clog2(DEPTH);
    localparam int         c_EW      = 2 * WIDTH + MODE_W;
    localparam logic [7:0] c_TO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [c_EW-1:0]   r_mem [DEPTH];
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_AW:0]     r_count;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;

    logic [WIDTH-1:0]  r_val1;
    logic [WIDTH-1:0]  r_val2;
    logic [MODE_W-1:0] r_mode;
    logic [7:0]        r_cnt;
    logic [RES_W-1:0]  r_rsp_result;
    logic              r_rsp_timeout;
    logic              r_err_stray;

    // ------------------------------------------------------------------------
    // Request FIFO (pointers wrap naturally because DEPTH is a power of two)
    // ------------------------------------------------------------------------
    assign w_full  = (r_count == (c_AW + 1)'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = bus.req_valid && !w_full;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {bus.req_val1, bus.req_val2, bus.req_mode};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_next = S_ISSUE;
                    w_pop  = 1'b1;
                end
            end
            S_ISSUE: w_next = S_WAIT;
            // valid_o on the last count cycle still wins over the timeout
            S_WAIT: begin
                if (bus.valid_o || (r_cnt == c_TO_LAST)) begin
                    w_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (bus.rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Operand, wait counter, response and error registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_val1        <= '0;
            r_val2        <= '0;
            r_mode        <= '0;
            r_cnt         <= '0;
            r_rsp_result  <= '0;
            r_rsp_timeout <= 1'b0;
            r_err_stray   <= 1'b0;
        end else begin
            // Operands are only replaced on a pop, so they hold through HOLD
            if (w_pop) begin
                {r_val1, r_val2, r_mode} <= r_mem[r_rd_ptr];
            end

            if (r_state == S_ISSUE) begin
                r_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt + 8'd1;
            end

            if (r_state == S_WAIT) begin
                if (bus.valid_o) begin
                    r_rsp_result  <= bus.result;
                    r_rsp_timeout <= 1'b0;
                end else if (r_cnt == c_TO_LAST) begin
                    r_rsp_result  <= '0;
                    r_rsp_timeout <= 1'b1;
                end
            end

            if (bus.valid_o && (r_state != S_WAIT)) begin
                r_err_stray <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.req_ready   = !w_full;
    assign bus.val1        = r_val1;
    assign bus.val2        = r_val2;
    assign bus.mode        = r_mode;
    assign bus.valid_i     = (r_state == S_ISSUE);
    assign bus.rsp_valid   = (r_state == S_HOLD);
    assign bus.rsp_result  = r_rsp_result;
    assign bus.rsp_timeout = r_rsp_timeout;
    assign busy            = (r_state != S_IDLE) || !w_empty;
    assign err_stray       = r_err_stray;

endmodule
`default_nettype wire

// File: tb/tb_alu_req_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_req_driver
// Description : Self-checking bench for alu_req_driver. A behavioural model
//               (request queues, an ALU that answers after a chosen latency,
//               and response expectations derived from that latency) predicts
//               every output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_req_driver;
    localparam int c_W     = 8;
    localparam int c_MW    = 3;
    localparam int c_RW    = 16;
    localparam int c_DEPTH = 4;
    localparam int c_TO    = 15;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic busy;
    logic err_stray;

    alu_req_driver_if #(.WIDTH(c_W), .MODE_W(c_MW), .RES_W(c_RW)) bus ();

    alu_req_driver #(
        .WIDTH(c_W), .MODE_W(c_MW), .RES_W(c_RW), .DEPTH(c_DEPTH), .TIMEOUT(c_TO)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .busy      (busy),
        .err_stray (err_stray)
    );

    always #5 clk = ~clk;

    // lat: WAIT cycle in which the ALU answers (1-based), 0 = never answers
    typedef struct {
        logic [7:0] v1;
        logic [7:0] v2;
        logic [2:0] m;
        int         lat;
    } op_t;

    op_t         gen_q[$];
    op_t         pend_q[$];
    op_t         cur;
    op_t         push_op;
    bit          cur_act, push_pend, cons_pend, exp_vi, exp_stray, force_stray;
    int          cur_age;
    int          alu_cnt = -1;
    logic [15:0] alu_res;
    int          req_pct = 100;
    int          rsp_pct = 100;
    int          rdy_low = 0;
    int          n_chk   = 0;
    int          n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] alu_fn(logic [7:0] a, logic [7:0] b, logic [2:0] m);
        case (m)
            3'd0:    return 16'(a) + 16'(b);
            3'd1:    return 16'(a) - 16'(b);
            3'd2:    return 16'(a) * 16'(b);
            3'd3:    return 16'(a & b);
            3'd4:    return 16'(a | b);
            3'd5:    return 16'(a ^ b);
            3'd6:    return {a, b};
            default: return ~{a, b};
        endcase
    endfunction

    function automatic bit answered(op_t o);
        return (o.lat >= 1) && (o.lat <= c_TO);
    endfunction

    // Cycle offset (from the valid_i cycle) at which rsp_valid must appear
    function automatic int rise_at(op_t o);
        return answered(o) ? o.lat + 1 : c_TO + 1;
    endfunction

    function automatic op_t mk_op(logic [7:0] a, logic [7:0] b, logic [2:0] m, int lat);
        op_t o;
        o.v1 = a; o.v2 = b; o.m = m; o.lat = lat;
        return o;
    endfunction

    // One clock cycle: observe and check at the falling edge, then drive.
    task automatic cycle();
        bit issued;
        bit exp_rv;
        @(negedge clk);
        issued = 1'b0;
        if (cons_pend) begin cur_act = 1'b0; cons_pend = 1'b0; end
        if (push_pend) begin pend_q.push_back(push_op); push_pend = 1'b0; end

        check("valid_i", bus.valid_i, exp_vi);
        if (bus.valid_i && !cur_act && pend_q.size() > 0) begin
            cur     = pend_q.pop_front();
            cur_act = 1'b1;
            cur_age = 0;
            issued  = 1'b1;
            alu_cnt = (cur.lat == 0) ? -1 : cur.lat;
            alu_res = alu_fn(bus.val1, bus.val2, bus.mode);
        end else if (cur_act) begin
            cur_age++;
        end

        if (cur_act) begin
            check("operands", {bus.val1, bus.val2, bus.mode}, {cur.v1, cur.v2, cur.m});
        end
        exp_rv = cur_act && (cur_age >= rise_at(cur));
        check("rsp_valid", bus.rsp_valid, exp_rv);
        if (exp_rv) begin
            check("rsp_result", bus.rsp_result,
                  answered(cur) ? alu_fn(cur.v1, cur.v2, cur.m) : 16'h0);
            check("rsp_timeout", bus.rsp_timeout, !answered(cur));
        end
        check("req_ready", bus.req_ready, pend_q.size() < c_DEPTH);
        check("busy", busy, cur_act || pend_q.size() > 0);
        check("err_stray", err_stray, exp_stray);
        exp_vi = !cur_act && pend_q.size() > 0;

        // ALU model
        bus.valid_o = 1'b0;
        bus.result  = 16'($urandom);
        if (!issued && alu_cnt > 0) begin
            alu_cnt--;
            if (alu_cnt == 0) begin
                bus.valid_o = 1'b1;
                bus.result  = alu_res;
                if (!(cur_act && cur_age >= 1 && cur_age <= c_TO)) exp_stray = 1'b1;
                alu_cnt = -1;
            end
        end
        if (force_stray) begin
            bus.valid_o = 1'b1;
            exp_stray   = 1'b1;
            force_stray = 1'b0;
        end

        // Requester: an offer, once made, is held until accepted
        if (gen_q.size() > 0 && (bus.req_valid || $urandom_range(99) < req_pct)) begin
            bus.req_valid = 1'b1;
            bus.req_val1  = gen_q[0].v1;
            bus.req_val2  = gen_q[0].v2;
            bus.req_mode  = gen_q[0].m;
        end else begin
            bus.req_valid = 1'b0;
            bus.req_val1  = 8'($urandom);
            bus.req_val2  = 8'($urandom);
            bus.req_mode  = 3'($urandom);
        end
        if (bus.req_valid && bus.req_ready) begin
            push_op   = gen_q.pop_front();
            push_pend = 1'b1;
        end

        // Response sink
        if (rdy_low > 0) begin
            bus.rsp_ready = 1'b0;
            rdy_low--;
        end else begin
            bus.rsp_ready = ($urandom_range(99) < rsp_pct);
        end
        if (bus.rsp_valid && bus.rsp_ready) cons_pend = 1'b1;
    endtask

    // Asserted between clock edges to exercise the asynchronous path
    task automatic async_reset(int cycles);
        #2 rst = 1'b1;
        #1;
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_valid_i", bus.valid_i, 0);
        check("rst_operands", {bus.val1, bus.val2, bus.mode}, 0);
        check("rst_rsp", {bus.rsp_result, bus.rsp_timeout}, 0);
        check("rst_busy", busy, 0);
        check("rst_err_stray", err_stray, 0);
        pend_q.delete();
        gen_q.delete();
        cur_act = 1'b0; push_pend = 1'b0; cons_pend = 1'b0;
        exp_vi  = 1'b0; exp_stray = 1'b0;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        repeat (cycles) cycle();
        rst = 1'b0;
    endtask

    task automatic run_until_idle(int max_cyc);
        int n = 0;
        while ((gen_q.size() > 0 || pend_q.size() > 0 || cur_act || push_pend || cons_pend)
               && n < max_cyc) begin
            cycle();
            n++;
        end
        check("drain_in_time", n < max_cyc, 1);
    endtask

    initial begin
        int n;
        bus.req_valid = 1'b0; bus.req_val1 = '0; bus.req_val2 = '0; bus.req_mode = '0;
        bus.rsp_ready = 1'b0; bus.valid_o = 1'b0; bus.result = '0;
        async_reset(2);

        // Single op, ALU latency 2: 0x12 + 0x34 = 0x0046
        gen_q.push_back(mk_op(8'h12, 8'h34, 3'd0, 2));
        run_until_idle(50);

        // FIFO full: six requests while responses are blocked
        rsp_pct = 0;
        for (int i = 0; i < 6; i++)
            gen_q.push_back(mk_op(8'($urandom), 8'($urandom), 3'($urandom), 1 + i % 3));
        repeat (12) cycle();
        check("full_req_ready", bus.req_ready, 0);
        rsp_pct = 100;
        run_until_idle(200);

        // Timeout followed by a normal op
        gen_q.push_back(mk_op(8'h55, 8'h0f, 3'd5, 0));
        gen_q.push_back(mk_op(8'h07, 8'h09, 3'd2, 3));
        run_until_idle(100);

        // Boundary: answer on last WAIT cycle, then one cycle too late
        gen_q.push_back(mk_op(8'ha0, 8'h0b, 3'd1, c_TO));
        run_until_idle(100);
        check("no_stray_boundary", err_stray, 0);
        gen_q.push_back(mk_op(8'h3c, 8'hc3, 3'd6, c_TO + 1));
        run_until_idle(100);
        repeat (3) cycle();
        check("stray_late", err_stray, 1);

        // Reset in WAIT with two ops queued; the ALU answers afterwards
        gen_q.push_back(mk_op(8'h11, 8'h22, 3'd0, 12));
        gen_q.push_back(mk_op(8'h33, 8'h44, 3'd4, 3));
        gen_q.push_back(mk_op(8'h66, 8'h77, 3'd3, 3));
        n = 0;
        while (!(cur_act && cur_age >= 4) && n < 30) begin cycle(); n++; end
        check("mid_op_reached", n < 30, 1);
        check("mid_busy", busy, 1);
        async_reset(2);
        repeat (14) cycle();
        check("stray_after_rst", err_stray, 1);

        // valid_o in IDLE
        async_reset(1);
        repeat (2) cycle();
        force_stray = 1'b1;
        repeat (2) cycle();
        check("stray_idle", err_stray, 1);

        // Response backpressure
        rdy_low = 16;
        gen_q.push_back(mk_op(8'hfe, 8'h02, 3'd0, 2));
        gen_q.push_back(mk_op(8'h81, 8'h18, 3'd7, 2));
        run_until_idle(100);

        // Randomised traffic
        req_pct = 70;
        rsp_pct = 60;
        for (int i = 0; i < 40; i++) begin
            int r;
            int lat;
            r = $urandom_range(0, 19);
            if (r < 15)       lat = r + 1;
            else if (r == 15) lat = c_TO + 1;
            else if (r == 16) lat = 0;
            else              lat = $urandom_range(1, 4);
            gen_q.push_back(mk_op(8'($urandom), 8'($urandom), 3'($urandom), lat));
        end
        run_until_idle(4000);
        repeat (4) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
